// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART: shifter states, register
// offsets and STATUS register layout.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;

  localparam int STAT_FULL    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_ACTIVE  = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 8;

  // Assemble the STATUS word; unlisted bits read as zero.
  function automatic logic [31:0] pack_status(
    input logic       full,
    input logic       empty,
    input logic       active,
    input logic       ovf,
    input logic [7:0] count
  );
    logic [31:0] s;
    s                    = 32'h0000_0000;
    s[STAT_FULL]         = full;
    s[STAT_EMPTY]        = empty;
    s[STAT_ACTIVE]       = active;
    s[STAT_OVF]          = ovf;
    s[STAT_CNT_LSB +: 8] = count;
    return s;
  endfunction

endpackage

// File: rtl/uart_mmio_tx_fifo.sv
// Synchronous FIFO with occupancy count; a push into a full FIFO is accepted
// when a pop happens in the same cycle. Intended for reuse by an RX path.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Qualify requests against occupancy.
  always_comb begin
    pop_ok_s  = pop & (count_r != {CW{1'b0}});
    push_ok_s = push & ((count_r != CW'(DEPTH)) | pop_ok_s);
  end

  // Storage array; no reset needed since reads are gated by the count.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign full  = (count_r == CW'(DEPTH));
  assign empty = (count_r == {CW{1'b0}});
  assign count = count_r;

endmodule

// File: rtl/uart_mmio_tx.sv
// Memory-mapped 8N1 UART transmitter: bus stores queue bytes in a FIFO that
// a baud-timed shifter drains onto the serial line; STATUS is pollable.
module uart_mmio_tx #(
  parameter int          CLKS_PER_BIT = 1250,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic        sel,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        tx_busy
);

  import uart_pkg::*;

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  tx_state_e         state_r;
  logic [BAUD_W-1:0] baud_r;
  logic [2:0]        bit_idx_r;
  logic [7:0]        shift_r;
  logic              tx_r;
  logic              ovf_r;

  logic              sel_s;
  logic [1:0]        offset_s;
  logic              push_req_s;
  logic              push_s;
  logic              pop_s;
  logic              drop_s;
  logic              ovf_clr_s;
  logic              baud_done_s;
  logic [31:0]       rdata_s;
  logic [7:0]        fifo_dout_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [CNT_W-1:0]  fifo_count_s;
  logic              unused_bits_s;

  assign unused_bits_s = ^{addr[1:0], wdata[31:8]};

  // Address decode and push/overflow qualification.
  always_comb begin
    sel_s       = (addr[31:4] == BASE_ADDR[31:4]);
    offset_s    = addr[3:2];
    push_req_s  = we & sel_s & (offset_s == REG_TXDATA);
    ovf_clr_s   = we & sel_s & (offset_s == REG_STATUS) & wdata[3];
    baud_done_s = (baud_r == BAUD_LAST);
    case (state_r)
      ST_IDLE: pop_s = ~fifo_empty_s;
      ST_STOP: pop_s = baud_done_s & ~fifo_empty_s;
      default: pop_s = 1'b0;
    endcase
    push_s = push_req_s & (~fifo_full_s | pop_s);
    drop_s = push_req_s & fifo_full_s & ~pop_s;
  end

  // Register read mux; TXDATA and reserved offsets read as zero.
  always_comb begin
    rdata_s = 32'h0000_0000;
    if (sel_s) begin
      case (offset_s)
        REG_STATUS: rdata_s = pack_status(fifo_full_s, fifo_empty_s,
                                          (state_r != ST_IDLE), ovf_r,
                                          8'(fifo_count_s));
        default:    rdata_s = 32'h0000_0000;
      endcase
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .din   (wdata[7:0]),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // Sticky overflow flag, cleared by software through STATUS.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_r <= 1'b0;
    end else if (drop_s) begin
      ovf_r <= 1'b1;
    end else if (ovf_clr_s) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  // Shifter FSM; pop conditions here must match pop_s above.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      baud_r    <= {BAUD_W{1'b0}};
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
      tx_r      <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          baud_r <= {BAUD_W{1'b0}};
          if (!fifo_empty_s) begin
            state_r <= ST_START;
            shift_r <= fifo_dout_s;
            tx_r    <= 1'b0;
          end else begin
            tx_r    <= 1'b1;
          end
        end
        ST_START: begin
          if (baud_done_s) begin
            state_r   <= ST_DATA;
            baud_r    <= {BAUD_W{1'b0}};
            bit_idx_r <= 3'd0;
            tx_r      <= shift_r[0];
          end else begin
            baud_r    <= baud_r + BAUD_W'(1);
          end
        end
        ST_DATA: begin
          if (baud_done_s) begin
            baud_r <= {BAUD_W{1'b0}};
            if (bit_idx_r == 3'd7) begin
              state_r <= ST_STOP;
              tx_r    <= 1'b1;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
              shift_r   <= {1'b0, shift_r[7:1]};
              tx_r      <= shift_r[1];
            end
          end else begin
            baud_r <= baud_r + BAUD_W'(1);
          end
        end
        ST_STOP: begin
          if (baud_done_s) begin
            baud_r <= {BAUD_W{1'b0}};
            if (!fifo_empty_s) begin
              state_r <= ST_START;
              shift_r <= fifo_dout_s;
              tx_r    <= 1'b0;
            end else begin
              state_r <= ST_IDLE;
              tx_r    <= 1'b1;
            end
          end else begin
            baud_r <= baud_r + BAUD_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          baud_r  <= {BAUD_W{1'b0}};
          tx_r    <= 1'b1;
        end
      endcase
    end
  end

  assign sel     = sel_s;
  assign rdata   = rdata_s;
  assign tx      = tx_r;
  assign tx_busy = (state_r != ST_IDLE) | ~fifo_empty_s;

endmodule

// File: tb/tb_uart_mmio_tx.sv
// Scoreboard bench for uart_mmio_tx: stores push expected bytes, a serial
// monitor decodes each frame cycle by cycle and compares against the queue.
module tb_uart_mmio_tx;

  localparam int          CPB   = 4;
  localparam int          FRAME = 10 * CPB;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        we = 1'b0;
  logic        sel;
  logic [31:0] rdata;
  logic        tx;
  logic        tx_busy;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int frame_cnt = 0;
  logic [7:0] exp_q[$];
  int         starts_q[$];

  uart_mmio_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(8), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .we(we),
    .sel(sel), .rdata(rdata), .tx(tx), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Serial monitor: frame starts on the first low sample while idle.
  logic       in_frame = 1'b0;
  int         idx = 0;
  logic [7:0] exp_b = 8'h00;
  logic [7:0] got_b = 8'h00;
  logic       shape_ok = 1'b1;
  always @(negedge clk) begin
    if (!rst) begin
      in_frame = 1'b0;
    end else begin
      if (!in_frame && tx === 1'b0) begin
        in_frame = 1'b1;
        idx = 0;
        shape_ok = 1'b1;
        got_b = 8'h00;
        starts_q.push_back(cyc);
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          exp_b = 8'h00;
          $display("FAIL unexpected_frame: frame started at cycle %0d, expected none", cyc);
        end else begin
          exp_b = exp_q.pop_front();
        end
      end
      if (in_frame) begin
        automatic int  bitn = idx / CPB;
        automatic logic lvl = (bitn == 0) ? 1'b0 : (bitn == 9) ? 1'b1 : exp_b[bitn-1];
        if (tx !== lvl) shape_ok = 1'b0;
        if (bitn >= 1 && bitn <= 8 && (idx % CPB) == CPB / 2) got_b[bitn-1] = tx;
        if (idx == FRAME - 1) begin
          check("frame_shape", {31'h0, shape_ok}, 32'h1);
          check("frame_data", {24'h0, got_b}, {24'h0, exp_b});
          frame_cnt++;
          in_frame = 1'b0;
        end else begin
          idx++;
        end
      end
    end
  end

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, output int sc);
    @(negedge clk);
    addr = a; wdata = d; we = 1'b1;
    @(posedge clk);
    #1;
    sc = cyc;
    we = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] r, output logic s);
    @(negedge clk);
    addr = a; we = 1'b0;
    #1;
    r = rdata;
    s = sel;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (tx_busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", {31'h0, tx_busy}, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic        s;
    int a, sc, b, n, fc, ns;

    // Reset state and register map
    repeat (3) @(negedge clk);
    check("reset_tx", {31'h0, tx}, 32'h1);
    check("reset_busy", {31'h0, tx_busy}, 32'h0);
    rst = 1'b1;
    bus_read(BASE + 32'h4, r, s);
    check("status_reset", r, 32'h0000_0002);
    check("sel_status", {31'h0, s}, 32'h1);
    bus_read(BASE + 32'h8, r, s);
    check("reserved_read", r, 32'h0);
    bus_read(BASE, r, s);
    check("txdata_read", r, 32'h0);
    bus_read(BASE + 32'h10, r, s);
    check("sel_outside", {31'h0, s}, 32'h0);
    check("rdata_outside", r, 32'h0);

    // Single byte 0x55: latency, count, busy drop
    exp_q.push_back(8'h55);
    bus_write(BASE, 32'h55, sc);
    bus_read(BASE + 32'h4, r, s);
    check("count_after_push", r, 32'h0000_0100);
    n = 0;
    while (starts_q.size() < 1 && n < 20) begin @(negedge clk); n++; end
    check("start_latency", starts_q.size() > 0 ? starts_q[0] - sc : -1, 32'd1);
    while (cyc < sc + FRAME) @(negedge clk);
    check("busy_in_stop", {31'h0, tx_busy}, 32'h1);
    @(negedge clk);
    check("busy_cleared", {31'h0, tx_busy}, 32'h0);
    check("idle_tx", {31'h0, tx}, 32'h1);

    // "Hi\n" back to back
    b = starts_q.size();
    exp_q.push_back(8'h48); exp_q.push_back(8'h69); exp_q.push_back(8'h0A);
    bus_write(BASE, 32'h48, sc);
    bus_write(BASE, 32'h69, sc);
    bus_write(BASE, 32'h0A, sc);
    wait_idle(3 * FRAME + 20);
    check("hi_frames", starts_q.size(), b + 3);
    if (starts_q.size() >= b + 3) begin
      check("gap_1", starts_q[b+1] - starts_q[b], FRAME);
      check("gap_2", starts_q[b+2] - starts_q[b+1], FRAME);
    end

    // Ten stores without waiting: nine accepted, tenth dropped
    for (int i = 0; i < 10; i++) begin
      if (i < 9) exp_q.push_back(8'hA0 + 8'(i));
      bus_write(BASE, 32'hA0 + i, sc);
    end
    bus_read(BASE + 32'h4, r, s);
    check("status_overflow", r, 32'h0000_080D);
    bus_write(BASE + 32'h8, 32'hFF, sc);
    bus_read(BASE + 32'h4, r, s);
    check("reserved_write_ignored", r, 32'h0000_080D);
    bus_write(BASE + 32'h4, 32'h8, sc);
    bus_read(BASE + 32'h4, r, s);
    check("overflow_cleared", r, 32'h0000_0805);
    wait_idle(10 * FRAME + 20);

    // Full FIFO, store coincides with STOP->START pop
    exp_q.push_back(8'h3C);
    bus_write(BASE, 32'h3C, a);
    for (int i = 1; i <= 8; i++) begin
      exp_q.push_back(8'hC0 + 8'(i));
      bus_write(BASE, 32'hC0 + i, sc);
    end
    exp_q.push_back(8'h7E);
    while (cyc < a + 39) @(negedge clk);
    bus_write(BASE, 32'h7E, sc);
    bus_read(BASE + 32'h4, r, s);
    check("coincident_push", r, 32'h0000_0805);
    wait_idle(10 * FRAME + 20);
    check("queue_drained", exp_q.size(), 32'd0);

    // Reset during DATA bit 3 of 0x96 (bit 3 = 0)
    exp_q.push_back(8'h96);
    bus_write(BASE, 32'h96, a);
    bus_write(BASE, 32'h5A, sc);
    while (cyc < a + 18) @(negedge clk);
    check("bit3_before_reset", {31'h0, tx}, 32'h0);
    #2;
    rst = 1'b0;
    #1;
    check("tx_high_on_reset", {31'h0, tx}, 32'h1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    bus_read(BASE + 32'h4, r, s);
    check("status_after_reset", r, 32'h0000_0002);
    fc = frame_cnt;
    ns = starts_q.size();
    repeat (100) @(negedge clk);
    check("no_frame_after_reset", frame_cnt, fc);
    check("no_start_after_reset", starts_q.size(), ns);
    check("busy_after_reset", {31'h0, tx_busy}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/uart_mmio_tx.md
# uart_mmio_tx

Memory-mapped 8N1 UART transmitter on the core's data-memory bus, beside data_ram. Replaces the fixed-string debug UART: software stores bytes to a TX data register, they queue in a small FIFO, and a baud-timed shifter drives the serial pin. A status register is readable by `lw` so firmware can poll for space or drain completion.

## Interface
- CLKS_PER_BIT, 1250, core clocks per serial bit (12 MHz / 9600); minimum 2
- FIFO_DEPTH, 8, TX FIFO entries; power of two, 2..64
- BASE_ADDR, 32'h0000_1000, byte address of register block; 16-byte aligned

- clk  in  1  core clock; all state on rising edge
- rst  in  1  reset; asynchronous assert, active-low (0 = reset); synchronous release handled upstream
- addr  in  32  data bus address (ALU result)
- wdata  in  32  store data (rs2 value)
- we  in  1  store strobe (MemWrite)
- sel  out  1  combinational: addr[31:4] == BASE_ADDR[31:4]
- rdata  out  32  combinational read data; 0 when sel=0
- tx  out  1  serial line, idle high
- tx_busy  out  1  high while shifter not IDLE or FIFO non-empty

## Operation
- Registers (offset = addr[3:2]): 0 TXDATA (W: push wdata[7:0]; R: 0); 1 STATUS (R); 2–3 reserved (R 0, W ignored)
- STATUS bits: [0] full, [1] empty, [2] shifter active, [3] overflow (sticky), [15:8] FIFO count; others 0
- Write to STATUS with wdata[3]=1 clears overflow; other bits ignored
- Push: we & sel & offset 0; accepted if !full, or if a pop occurs the same cycle; otherwise dropped and overflow set
- Shifter FSM: IDLE, START, DATA, STOP
  - IDLE: if FIFO non-empty, pop into shift reg, -> START
  - START: tx=0 for CLKS_PER_BIT clocks -> DATA, bit index 0
  - DATA: tx=shift[0], LSB first, CLKS_PER_BIT clocks per bit; after bit 7 -> STOP
  - STOP: tx=1 for CLKS_PER_BIT clocks; then pop and -> START if FIFO non-empty, else -> IDLE
- Baud counter reloads to 0 on every state/bit change; counter width $clog2(CLKS_PER_BIT)
- FIFO count width $clog2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH

## Timing
- Reset values: tx=1, tx_busy=0, FIFO empty (count 0), overflow 0, state IDLE; sel/rdata follow addr combinationally
- Push at edge E0 -> count visible after E0; if IDLE, pop at E1, tx falls after E1 (one clock push-to-start)
- Frame = exactly 10*CLKS_PER_BIT clocks; back-to-back frames with no idle gap
- tx is a registered output; no combinational path from bus to tx
- Simultaneous push and pop: count unchanged; with full FIFO push is accepted
- Push while empty and IDLE: byte passes through FIFO (no bypass); latency as above
- Reset mid-frame: tx high immediately, frame abandoned, queued bytes discarded
- tx_busy drops in the clock after the last stop bit ends with FIFO empty

## Structure
- Package uart_pkg: state enum (IDLE, START, DATA, STOP), register offsets (TXDATA=0, STATUS=1), STATUS bit positions
- Sub-module sync_fifo (WIDTH, DEPTH params; push/pop/full/empty/count); reused later for an RX path
- Top: address decode, STATUS mux, overflow flag, FSM with baud and bit counters

## Test plan
- CLKS_PER_BIT=4: store 8'h55 to BASE_ADDR -> tx low 4 clocks starting 1 clock after store, then 1,0,1,0,1,0,1,0 each 4 clocks, high 4 clocks; tx_busy clears
- Store "Hi\n" (8'h48, 8'h69, 8'h0A) consecutively -> three contiguous 40-clock frames, no idle gap, correct LSB-first bits
- Store 10 bytes without waiting (DEPTH=8, first pops immediately) -> 9 accepted, 10th dropped, STATUS[3]=1; write STATUS 32'h8 -> STATUS[3]=0
- Read BASE_ADDR+4 after reset -> rdata=32'h0000_0002; read BASE_ADDR+8 -> 0; addr=BASE_ADDR+32'h10 -> sel=0, rdata=0
- FIFO full, store coincides with STOP->START pop -> byte accepted, count stays 8, overflow stays 0
- Assert rst mid DATA bit 3 -> tx=1 same cycle, STATUS reads 32'h2 after release, no further frame emitted
